flag_branch_unit: RTL and testbench

- Consumer end of the 64-bit ALU condition-flag interface: latches N/Z/V/C from flag-setting instructions in EX into the architectural flag register, and resolves B.cond / CBZ / CBNZ branches in ID.
- Handles the EX-to-ID flag hazard by forwarding or stalling, and keeps taken-branch and stall event counters for the CPU's debug port.

---
 rtl/flag_branch_unit.sv | 148 ++++++++++++++
 tb/tb_flag_branch_unit.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/flag_branch_unit.sv
// flag_branch_unit: holds the architectural N/Z/V/C flag register and resolves
// B.cond / CBZ / CBNZ branches in ID. It also keeps saturating counters of
// taken branches and stall cycles for the debug port.
//
// Build option FLAG_FWD_EN: when defined, the EX-stage ALU flags are forwarded
// into the ID condition decode, so a back-to-back flag-set and B.cond never
// stalls. When undefined, that hazard costs exactly one stall cycle, and
// br_taken depends only on the registered flags.
module flag_branch_unit #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ex_valid,
    input  logic             ex_set_flags,
    input  logic             ex_negative,
    input  logic             ex_zero,
    input  logic             ex_overflow,
    input  logic             ex_carry_out,
    input  logic             flush,
    input  logic             id_valid,
    input  logic             id_is_bcond,
    input  logic             id_is_cbz,
    input  logic             id_is_cbnz,
    input  logic [3:0]       id_cond,
    input  logic             id_reg_zero,
    output logic [3:0]       flags,
    output logic             br_taken,
    output logic             stall,
    output logic [CNT_W-1:0] taken_cnt,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [3:0] {
        COND_EQ = 4'h0,
        COND_NE = 4'h1,
        COND_HS = 4'h2,
        COND_LO = 4'h3,
        COND_MI = 4'h4,
        COND_PL = 4'h5,
        COND_VS = 4'h6,
        COND_VC = 4'h7,
        COND_HI = 4'h8,
        COND_LS = 4'h9,
        COND_GE = 4'hA,
        COND_LT = 4'hB,
        COND_GT = 4'hC,
        COND_LE = 4'hD,
        COND_AL = 4'hE,
        COND_NV = 4'hF
    } cond_e;

    logic [3:0] ex_flags;
    logic [3:0] eff;
    logic       haz;
    logic       flag_write;
    logic       stall_int;
    logic       cond_true;
    logic       branch_hit;
    logic       eff_n;
    logic       eff_z;
    logic       eff_v;
    logic       eff_c;
    cond_e      cond;

    assign ex_flags   = {ex_negative, ex_zero, ex_overflow, ex_carry_out};
    assign flag_write = ex_valid & ex_set_flags & ~flush;
    assign haz        = ex_valid & ex_set_flags & id_valid & id_is_bcond & ~flush;
    assign cond       = cond_e'(id_cond);

`ifdef FLAG_FWD_EN
    assign eff       = haz ? ex_flags : flags;
    assign stall_int = 1'b0;
`else
    assign eff       = flags;
    assign stall_int = haz;
`endif

    assign eff_n = eff[3];
    assign eff_z = eff[2];
    assign eff_v = eff[1];
    assign eff_c = eff[0];

    // Decode the B.cond condition field against the effective flags
    always_comb begin
        cond_true = 1'b1;
        case (cond)
            COND_EQ: cond_true = eff_z;
            COND_NE: cond_true = ~eff_z;
            COND_HS: cond_true = eff_c;
            COND_LO: cond_true = ~eff_c;
            COND_MI: cond_true = eff_n;
            COND_PL: cond_true = ~eff_n;
            COND_VS: cond_true = eff_v;
            COND_VC: cond_true = ~eff_v;
            COND_HI: cond_true = eff_c & ~eff_z;
            COND_LS: cond_true = ~eff_c | eff_z;
            COND_GE: cond_true = (eff_n == eff_v);
            COND_LT: cond_true = (eff_n != eff_v);
            COND_GT: cond_true = ~eff_z & (eff_n == eff_v);
            COND_LE: cond_true = eff_z | (eff_n != eff_v);
            default: cond_true = 1'b1;
        endcase
    end

    // Select the branch outcome by kind, giving bcond priority over cbz, then cbnz
    always_comb begin
        branch_hit = 1'b0;
        if (id_is_bcond) begin
            branch_hit = cond_true;
        end else if (id_is_cbz) begin
            branch_hit = id_reg_zero;
        end else if (id_is_cbnz) begin
            branch_hit = ~id_reg_zero;
        end
    end

    assign stall    = reset & stall_int;
    assign br_taken = reset & id_valid & ~flush & ~stall_int & branch_hit;

    // Architectural flag register, written by unflushed flag-setting EX instructions
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flags <= 4'b0000;
        end else if (flag_write) begin
            flags <= ex_flags;
        end
    end

    // Saturating count of cycles with a taken branch
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            taken_cnt <= '0;
        end else if (br_taken && (taken_cnt != {CNT_W{1'b1}})) begin
            taken_cnt <= taken_cnt + CNT_W'(1);
        end
    end

    // Saturating count of stall cycles
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_flag_branch_unit.sv
// tb_flag_branch_unit: directed test of flag_branch_unit with a reference model
// that is checked on every falling edge, plus hand-computed literal checks.
// A narrow counter width lets saturation be reached with a few branches.
module tb_flag_branch_unit;

    localparam int CNT_W = 4;

    logic             clk;
    logic             reset;
    logic             ex_valid;
    logic             ex_set_flags;
    logic             ex_negative;
    logic             ex_zero;
    logic             ex_overflow;
    logic             ex_carry_out;
    logic             flush;
    logic             id_valid;
    logic             id_is_bcond;
    logic             id_is_cbz;
    logic             id_is_cbnz;
    logic [3:0]       id_cond;
    logic             id_reg_zero;
    logic [3:0]       flags;
    logic             br_taken;
    logic             stall;
    logic [CNT_W-1:0] taken_cnt;
    logic [CNT_W-1:0] stall_cnt;

    int checks = 0;
    int errors = 0;

    logic [3:0]       m_flags;
    logic [CNT_W-1:0] m_taken;
    logic [CNT_W-1:0] m_stall;

    logic [15:0] table_0000;
    logic [15:0] table_1011;

    flag_branch_unit #(.CNT_W(CNT_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .ex_valid     (ex_valid),
        .ex_set_flags (ex_set_flags),
        .ex_negative  (ex_negative),
        .ex_zero      (ex_zero),
        .ex_overflow  (ex_overflow),
        .ex_carry_out (ex_carry_out),
        .flush        (flush),
        .id_valid     (id_valid),
        .id_is_bcond  (id_is_bcond),
        .id_is_cbz    (id_is_cbz),
        .id_is_cbnz   (id_is_cbnz),
        .id_cond      (id_cond),
        .id_reg_zero  (id_reg_zero),
        .flags        (flags),
        .br_taken     (br_taken),
        .stall        (stall),
        .taken_cnt    (taken_cnt),
        .stall_cnt    (stall_cnt)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Condition rules: the upper three bits pick a base test, bit 0 inverts it, 111x is always
    function automatic logic cond_holds(input logic [3:0] c, input logic [3:0] f);
        logic n, z, v, cy, base;
        n = f[3];
        z = f[2];
        v = f[1];
        cy = f[0];
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cy;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cy && !z;
            3'd5: base = (n == v);
            3'd6: base = !z && (n == v);
            default: base = 1'b1;
        endcase
        if (c[3:1] == 3'd7) return 1'b1;
        return base ^ c[0];
    endfunction

    // Expected {stall, br_taken} for the current inputs and model flags
    function automatic logic [1:0] model_outputs();
        logic hazard, exp_stall, hit;
        logic [3:0] eff;
        if (!reset) return 2'b00;
        hazard = ex_valid && ex_set_flags && id_valid && id_is_bcond && !flush;
`ifdef FLAG_FWD_EN
        eff = hazard ? {ex_negative, ex_zero, ex_overflow, ex_carry_out} : m_flags;
        exp_stall = 1'b0;
`else
        eff = m_flags;
        exp_stall = hazard;
`endif
        if (id_is_bcond) hit = cond_holds(id_cond, eff);
        else if (id_is_cbz) hit = id_reg_zero;
        else if (id_is_cbnz) hit = !id_reg_zero;
        else hit = 1'b0;
        return {exp_stall, id_valid && !flush && !exp_stall && hit};
    endfunction

    // Reference state: flag register and saturating counters
    always @(posedge clk or negedge reset) begin
        logic [1:0] o;
        if (!reset) begin
            m_flags <= 4'b0000;
            m_taken <= '0;
            m_stall <= '0;
        end else begin
            o = model_outputs();
            if (ex_valid && ex_set_flags && !flush)
                m_flags <= {ex_negative, ex_zero, ex_overflow, ex_carry_out};
            if (o[0] && m_taken != {CNT_W{1'b1}}) m_taken <= m_taken + 1'b1;
            if (o[1] && m_stall != {CNT_W{1'b1}}) m_stall <= m_stall + 1'b1;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    // Compare every DUT output against the model on each falling edge
    always @(negedge clk) begin
        logic [1:0] o;
        o = model_outputs();
        checkOutput("model_flags", 32'(flags), 32'(m_flags));
        checkOutput("model_br_taken", 32'(br_taken), 32'(o[0]));
        checkOutput("model_stall", 32'(stall), 32'(o[1]));
        checkOutput("model_taken_cnt", 32'(taken_cnt), 32'(m_taken));
        checkOutput("model_stall_cnt", 32'(stall_cnt), 32'(m_stall));
    end

    // Drive one cycle of inputs just after the rising edge; kind is {bcond, cbz, cbnz}
    task automatic applyStimulus(input logic ev, input logic es, input logic [3:0] ef,
                                 input logic fl, input logic iv, input logic [2:0] kind,
                                 input logic [3:0] cond, input logic rz);
        @(posedge clk);
        #1;
        ex_valid     = ev;
        ex_set_flags = es;
        {ex_negative, ex_zero, ex_overflow, ex_carry_out} = ef;
        flush        = fl;
        id_valid     = iv;
        {id_is_bcond, id_is_cbz, id_is_cbnz} = kind;
        id_cond      = cond;
        id_reg_zero  = rz;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 3'b000, 4'h0, 1'b0);
    endtask

    initial begin
        reset = 1'b0;
        ex_valid = 1'b0;
        ex_set_flags = 1'b0;
        {ex_negative, ex_zero, ex_overflow, ex_carry_out} = 4'h0;
        flush = 1'b0;
        id_valid = 1'b0;
        {id_is_bcond, id_is_cbz, id_is_cbnz} = 3'b000;
        id_cond = 4'h0;
        id_reg_zero = 1'b0;
        table_0000 = 16'hD6AA;
        table_1011 = 16'hD556;

        #3;
        checkOutput("reset_flags", 32'(flags), 32'h0);
        checkOutput("reset_taken_cnt", 32'(taken_cnt), 32'h0);
        checkOutput("reset_stall_cnt", 32'(stall_cnt), 32'h0);
        checkOutput("reset_stall", 32'(stall), 32'h0);
        @(posedge clk);
        #1 reset = 1'b1;

        // SUBS giving Z=1, C=1, then B.EQ
        applyStimulus(1'b1, 1'b1, 4'b0101, 1'b0, 1'b0, 3'b000, 4'h0, 1'b0);
        idle();
        #3 checkOutput("subs_flags", 32'(flags), 32'h5);
        applyStimulus(1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 3'b100, 4'h0, 1'b0);
        #3 checkOutput("beq_taken", 32'(br_taken), 32'h1);
        idle();
        #3 checkOutput("beq_taken_cnt", 32'(taken_cnt), 32'h1);

        // SUBS N=1 back-to-back with B.LT
        applyStimulus(1'b1, 1'b1, 4'b1000, 1'b0, 1'b1, 3'b100, 4'hB, 1'b0);
`ifdef FLAG_FWD_EN
        #3 checkOutput("haz_fwd_taken", 32'(br_taken), 32'h1);
        checkOutput("haz_fwd_stall", 32'(stall), 32'h0);
`else
        #3 checkOutput("haz_stall", 32'(stall), 32'h1);
        checkOutput("haz_stall_taken", 32'(br_taken), 32'h0);
        applyStimulus(1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 3'b100, 4'hB, 1'b0);
        #3 checkOutput("haz_resolve_taken", 32'(br_taken), 32'h1);
        checkOutput("haz_resolve_stall", 32'(stall), 32'h0);
`endif
        idle();
        #3 checkOutput("haz_taken_cnt", 32'(taken_cnt), 32'h2);
`ifdef FLAG_FWD_EN
        checkOutput("haz_stall_cnt", 32'(stall_cnt), 32'h0);
`else
        checkOutput("haz_stall_cnt", 32'(stall_cnt), 32'h1);
`endif

        // Sweep every condition code against two flag patterns
        applyStimulus(1'b1, 1'b1, 4'b0000, 1'b0, 1'b0, 3'b000, 4'h0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 3'b100, 4'(i), 1'b0);
            #3 checkOutput($sformatf("cond_%0h_f0000", i), 32'(br_taken), 32'(table_0000[i]));
        end
        applyStimulus(1'b1, 1'b1, 4'b1011, 1'b0, 1'b0, 3'b000, 4'h0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 3'b100, 4'(i), 1'b0);
            #3 checkOutput($sformatf("cond_%0h_f1011", i), 32'(br_taken), 32'(table_1011[i]));
        end
        idle();
        #3 checkOutput("taken_cnt_saturated", 32'(taken_cnt), 32'hF);
        applyStimulus(1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 3'b100, 4'hE, 1'b0);
        idle();
        #3 checkOutput("taken_cnt_no_wrap", 32'(taken_cnt), 32'hF);

        // CBZ / CBNZ ignore flags and the EX flag-setter
        applyStimulus(1'b1, 1'b1, 4'b0010, 1'b0, 1'b1, 3'b010, 4'h0, 1'b1);
        #3 checkOutput("cbz_taken", 32'(br_taken), 32'h1);
        checkOutput("cbz_stall", 32'(stall), 32'h0);
        applyStimulus(1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 3'b001, 4'h0, 1'b1);
        #3 checkOutput("cbnz_not_taken", 32'(br_taken), 32'h0);

        // bcond wins over cbz: B.EQ with Z=0 is not taken although the register is zero
        applyStimulus(1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 3'b110, 4'h0, 1'b1);
        #3 checkOutput("priority_bcond", 32'(br_taken), 32'h0);

        // Flush kills both the flag write and the branch
        applyStimulus(1'b1, 1'b1, 4'b1000, 1'b1, 1'b1, 3'b100, 4'hE, 1'b0);
        #3 checkOutput("flush_taken", 32'(br_taken), 32'h0);
        idle();
        #3 checkOutput("flush_flags_hold", 32'(flags), 32'h2);

        // Asynchronous reset in mid-cycle with all flags set and a pending hazard
        applyStimulus(1'b1, 1'b1, 4'b1111, 1'b0, 1'b0, 3'b000, 4'h0, 1'b0);
        applyStimulus(1'b1, 1'b1, 4'b1111, 1'b0, 1'b1, 3'b100, 4'h0, 1'b0);
        #1 checkOutput("pre_reset_flags", 32'(flags), 32'hF);
        reset = 1'b0;
        #1;
        checkOutput("async_reset_flags", 32'(flags), 32'h0);
        checkOutput("async_reset_taken_cnt", 32'(taken_cnt), 32'h0);
        checkOutput("async_reset_stall_cnt", 32'(stall_cnt), 32'h0);
        checkOutput("async_reset_stall", 32'(stall), 32'h0);
        checkOutput("async_reset_taken", 32'(br_taken), 32'h0);
        #1 reset = 1'b1;
        idle();
        idle();
        #3;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
